// File: rtl/reg_file_mp.sv
// Multi-port register file: NRD combinational read ports, two write ports and a per-register busy scoreboard.
// Optional write-through bypass is enabled by defining REGFILE_BYPASS_EN.
module reg_file_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  wa_en,
    input  logic [ADDR_W-1:0]     wa_addr,
    input  logic [DATA_W-1:0]     wa_data,
    input  logic                  wb_en,
    input  logic [ADDR_W-1:0]     wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr,
    output logic                  any_busy
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_r [NREG];
    logic [NREG-1:0]   busy_r;
    logic [NREG-1:0]   busy_nxt_s;
    logic [NREG-1:0]   wa_hit_s;
    logic [NREG-1:0]   wb_hit_s;
    logic [NREG-1:0]   iss_hit_s;

    // One-hot decode of write and issue targets; bit 0 never decodes so r0 stays zero and idle.
    always_comb begin
        wa_hit_s  = '0;
        wb_hit_s  = '0;
        iss_hit_s = '0;
        for (int i = 1; i < NREG; i++) begin
            wa_hit_s[i]  = wa_en  && (wa_addr  == ADDR_W'(i));
            wb_hit_s[i]  = wb_en  && (wb_addr  == ADDR_W'(i));
            iss_hit_s[i] = iss_en && (iss_addr == ADDR_W'(i));
        end
    end

    // Scoreboard next state: a new issue overrides a same-cycle writeback clear.
    always_comb begin
        busy_nxt_s = '0;
        for (int i = 0; i < NREG; i++) begin
            busy_nxt_s[i] = iss_hit_s[i] | (busy_r[i] & ~(wa_hit_s[i] | wb_hit_s[i]));
        end
    end

    // Register array and busy bits; port B overrides port A on an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= '0;
            end
            busy_r <= '0;
        end else begin
            busy_r <= busy_nxt_s;
            for (int i = 1; i < NREG; i++) begin
                if (wb_hit_s[i]) begin
                    regs_r[i] <= wb_data;
                end else if (wa_hit_s[i]) begin
                    regs_r[i] <= wa_data;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr_s;
        assign addr_s = rd_addr[k*ADDR_W +: ADDR_W];

`ifdef REGFILE_BYPASS_EN
        // Write-through read: in-flight write data is forwarded, and busy only reflects a same-cycle reissue.
        always_comb begin
            if (wb_hit_s[addr_s]) begin
                rd_data[k*DATA_W +: DATA_W] = wb_data;
                rd_busy[k]                  = iss_hit_s[addr_s];
            end else if (wa_hit_s[addr_s]) begin
                rd_data[k*DATA_W +: DATA_W] = wa_data;
                rd_busy[k]                  = iss_hit_s[addr_s];
            end else begin
                rd_data[k*DATA_W +: DATA_W] = regs_r[addr_s];
                rd_busy[k]                  = busy_r[addr_s];
            end
        end
`else
        // Read of registered state only; r0 and its busy bit are held at zero.
        always_comb begin
            rd_data[k*DATA_W +: DATA_W] = regs_r[addr_s];
            rd_busy[k]                  = busy_r[addr_s];
        end
`endif
    end

    assign any_busy = |busy_r;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp using a scoreboard queue of expected read-port values.
module tb_reg_file_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wa_en, wb_en, iss_en;
    logic [4:0]  wa_addr, wb_addr, iss_addr;
    logic [31:0] wa_data, wb_data;
    logic        any_busy;

    logic [11:0] p_rd_addr;
    logic [63:0] p_rd_data;
    logic [3:0]  p_rd_busy;
    logic        p_wa_en, p_wb_en, p_iss_en;
    logic [2:0]  p_wa_addr, p_wb_addr, p_iss_addr;
    logic [15:0] p_wa_data, p_wb_data;
    logic        p_any_busy;

    typedef struct {
        int          kind;
        int          port;
        logic [31:0] data;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .any_busy(any_busy)
    );

    reg_file_mp #(.DATA_W(16), .ADDR_W(3), .NRD(4)) dut_p (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(p_rd_addr), .rd_data(p_rd_data), .rd_busy(p_rd_busy),
        .wa_en(p_wa_en), .wa_addr(p_wa_addr), .wa_data(p_wa_data),
        .wb_en(p_wb_en), .wb_addr(p_wb_addr), .wb_data(p_wb_data),
        .iss_en(p_iss_en), .iss_addr(p_iss_addr), .any_busy(p_any_busy)
    );

    // kind 0: rd_data, 1: rd_busy, 2: any_busy, 3: parametrised-instance rd_data
    task automatic push(input string tag, input int kind, input int port, input logic [31:0] data);
        exp_t e;
        e.kind = kind;
        e.port = port;
        e.data = data;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic exp_rd(input string tag, input int port, input logic [31:0] data, input logic busy);
        push(tag, 0, port, data);
        push(tag, 1, port, {31'd0, busy});
    endtask

    task automatic check_all();
        exp_t        e;
        string       t;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            case (e.kind)
                0:       obs = rd_data[e.port*32 +: 32];
                1:       obs = {31'd0, rd_busy[e.port]};
                2:       obs = {31'd0, any_busy};
                3:       obs = {16'd0, p_rd_data[e.port*16 +: 16]};
                default: obs = 32'hxxxx_xxxx;
            endcase
            checks++;
            assert (obs === e.data) else begin
                errors++;
                $error("FAIL %s kind %0d port %0d got %h expected %h", t, e.kind, e.port, obs, e.data);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wa_en = 1'b0; wa_addr = 5'd0; wa_data = 32'd0;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        iss_en = 1'b0; iss_addr = 5'd0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        set_rd(5'd5, 5'd0);
        p_wa_en = 1'b0; p_wa_addr = 3'd0; p_wa_data = 16'd0;
        p_wb_en = 1'b0; p_wb_addr = 3'd0; p_wb_data = 16'd0;
        p_iss_en = 1'b0; p_iss_addr = 3'd0; p_rd_addr = 12'd0;
        cyc();
        cyc();
        exp_rd("reset_r5", 0, 32'd0, 1'b0);
        push("reset_any", 2, 0, 32'd0);
        check_all();
        rst_n = 1'b1;
        cyc();

        // R0 is hardwired: write and issue to r0 are ignored
        set_rd(5'd0, 5'd0);
        wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFF_FFFF;
        iss_en = 1'b1; iss_addr = 5'd0;
        #1;
        exp_rd("r0_same", 0, 32'd0, 1'b0);
        check_all();
        cyc();
        idle();
        #1;
        exp_rd("r0_p0", 0, 32'd0, 1'b0);
        exp_rd("r0_p1", 1, 32'd0, 1'b0);
        push("r0_any", 2, 0, 32'd0);
        check_all();

        // Collision on r7: port B wins
        set_rd(5'd7, 5'd7);
        wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h11;
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h22;
        #1;
        exp_rd("coll_same", 0, BYP ? 32'h22 : 32'h0, 1'b0);
        check_all();
        cyc();
        idle();
        #1;
        exp_rd("coll_p0", 0, 32'h22, 1'b0);
        exp_rd("coll_p1", 1, 32'h22, 1'b0);
        check_all();

        // Scoreboard on r3
        set_rd(5'd3, 5'd7);
        iss_en = 1'b1; iss_addr = 5'd3;
        #1;
        exp_rd("sb_c0", 0, 32'h0, 1'b0);
        push("sb_c0_any", 2, 0, 32'd0);
        check_all();
        cyc();
        idle();
        #1;
        exp_rd("sb_c1", 0, 32'h0, 1'b1);
        push("sb_c1_any", 2, 0, 32'd1);
        check_all();
        cyc();
        cyc();
        cyc();
        wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'h55;
        iss_en = 1'b1; iss_addr = 5'd3;
        #1;
        exp_rd("sb_c4_same", 0, BYP ? 32'h55 : 32'h0, 1'b1);
        check_all();
        cyc();
        idle();
        #1;
        exp_rd("sb_c5", 0, 32'h55, 1'b1);
        check_all();
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h66;
        #1;
        exp_rd("sb_c5_same", 0, BYP ? 32'h66 : 32'h55, BYP ? 1'b0 : 1'b1);
        check_all();
        cyc();
        idle();
        #1;
        exp_rd("sb_c6", 0, 32'h66, 1'b0);
        push("sb_c6_any", 2, 0, 32'd0);
        check_all();

        // Bypass on busy r9
        set_rd(5'd3, 5'd9);
        wa_en = 1'b1; wa_addr = 5'd9; wa_data = 32'h1234_5678;
        cyc();
        idle();
        iss_en = 1'b1; iss_addr = 5'd9;
        cyc();
        idle();
        #1;
        exp_rd("byp_pre", 1, 32'h1234_5678, 1'b1);
        check_all();
        wa_en = 1'b1; wa_addr = 5'd9; wa_data = 32'hCAFE_0001;
        #1;
        exp_rd("byp_same", 1, BYP ? 32'hCAFE_0001 : 32'h1234_5678, BYP ? 1'b0 : 1'b1);
        check_all();
        cyc();
        idle();
        #1;
        exp_rd("byp_next", 1, 32'hCAFE_0001, 1'b0);
        check_all();

        // Reset mid-run: r5 loaded and busy, then a 3 ns reset pulse between edges
        set_rd(5'd5, 5'd9);
        wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEAD_BEEF;
        iss_en = 1'b1; iss_addr = 5'd5;
        cyc();
        idle();
        #1;
        exp_rd("rst_pre", 0, 32'hDEAD_BEEF, 1'b1);
        push("rst_pre_any", 2, 0, 32'd1);
        check_all();
        rst_n = 1'b0;
        #1;
        exp_rd("rst_r5", 0, 32'd0, 1'b0);
        exp_rd("rst_r9", 1, 32'd0, 1'b0);
        push("rst_any", 2, 0, 32'd0);
        check_all();
        #2;
        rst_n = 1'b1;
        cyc();
        exp_rd("rst_after", 0, 32'd0, 1'b0);
        push("rst_after_any", 2, 0, 32'd0);
        check_all();

        // Parametrised instance: 16-bit data, 8 registers, 4 read ports
        for (int i = 1; i < 8; i++) begin
            p_wa_en = 1'b1;
            p_wa_addr = 3'(i);
            p_wa_data = 16'(i * 16'h111);
            cyc();
        end
        p_wa_en = 1'b0;
        p_rd_addr = {3'd2, 3'd4, 3'd1, 3'd7};
        #1;
        push("par_a0", 3, 0, 32'h777);
        push("par_a1", 3, 1, 32'h111);
        push("par_a2", 3, 2, 32'h444);
        push("par_a3", 3, 3, 32'h222);
        check_all();
        p_rd_addr = {3'd6, 3'd5, 3'd3, 3'd0};
        #1;
        push("par_b0", 3, 0, 32'h0);
        push("par_b1", 3, 1, 32'h333);
        push("par_b2", 3, 2, 32'h555);
        push("par_b3", 3, 3, 32'h666);
        check_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
